// File: rtl/block_c_pkg.sv
// block_c_pkg: shared types and sizing helpers for block_c.
package block_c_pkg;
   typedef enum logic {SHIFT, PARITY} state_t;
   localparam int DATA_WIDTH_MAX = 32;
   function automatic int level_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/block_c_fifo.sv
// block_c_fifo: show-ahead FIFO with occupancy level and drop indication.
module block_c_fifo
   import block_c_pkg::*;
#(
   parameter int W = 8,
   parameter int DEPTH = 4,
   localparam int LW = level_w(DEPTH),
   localparam int PW = $clog2(DEPTH)
) (
   input logic clk,
   input logic rst,
   input logic push,
   input logic ready,
   input logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic valid,
   output logic [LW-1:0] level,
   output logic drop
);
   logic [W-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic pop, push_ok;
   assign valid = level != '0;
   assign pop = valid && ready;
   // a full FIFO still takes a word when the head leaves on the same edge
   assign push_ok = push && (level != LW'(DEPTH) || pop);
   assign drop = push && !push_ok;
   assign dout = valid ? mem[rd_ptr] : '0;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(push_ok);
         rd_ptr <= rd_ptr + PW'(pop);
         level <= level + LW'(push_ok) - LW'(pop);
      end
   always_ff @(posedge clk)
      if (push_ok) mem[wr_ptr] <= din;
endmodule

// File: rtl/block_c.sv
// block_c: LSB-first serial-to-word capture into a show-ahead FIFO with sticky overflow.
// Define BLOCK_C_PARITY_EN to add an even-parity bit per word and the parity_err pulse.
module block_c
   import block_c_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input logic clk,
   input logic rst,
   input logic data_en,
   input logic data_in_out_2,
   input logic data_ready,
   input logic clr_overflow,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic data_valid,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
   output logic overflow
`ifdef BLOCK_C_PARITY_EN
   ,
   output logic parity_err
`endif
);
   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
   logic [DATA_WIDTH-1:0] shreg, shreg_nx, word;
   logic [CW-1:0] bit_cnt;
   logic shift_en, push, drop;
   always_comb begin
      shreg_nx = shreg;
      shreg_nx[bit_cnt] = data_in_out_2;
   end
`ifdef BLOCK_C_PARITY_EN
   state_t state, state_nx;
   logic par_bad;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= SHIFT;
      else state <= state_nx;
   always_comb
      state_nx = !data_en ? state : (state == SHIFT && bit_cnt == LAST) ? PARITY : SHIFT;
   always_comb begin
      shift_en = data_en && state == SHIFT;
      par_bad = ^shreg ^ data_in_out_2;
      push = data_en && state == PARITY && !par_bad;
      word = shreg;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) parity_err <= 1'b0;
      else parity_err <= data_en && state == PARITY && par_bad;
`else
   // the last bit bypasses shreg so the word is pushed on its own strobe
   always_comb begin
      shift_en = data_en;
      push = data_en && bit_cnt == LAST;
      word = shreg_nx;
   end
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         shreg <= '0;
         bit_cnt <= '0;
      end else if (shift_en) begin
         shreg <= shreg_nx;
         bit_cnt <= bit_cnt == LAST ? '0 : bit_cnt + CW'(1);
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
   block_c_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(push),
      .ready(data_ready),
      .din(word),
      .dout(data_out),
      .valid(data_valid),
      .level(fifo_level),
      .drop(drop)
   );
endmodule

// File: doc/block_c.md
# block_c

Serial-to-word capture stage that sits directly downstream of `block_b`. It samples the `data_en`-qualified serial stream on `data_in_out_2`, assembles the bits LSB-first into `DATA_WIDTH`-bit words, and buffers them in a small show-ahead FIFO. Words leave on a valid/ready handshake toward the next consumer. Buffer overruns are reported through a sticky `overflow` flag.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: assembled word width; legal range 2..32.
- `FIFO_DEPTH`, default 4: number of FIFO entries; must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_en`  in  1  serial bit strobe; `data_in_out_2` is sampled only when this is 1.
- `data_in_out_2`  in  1  serial data bit, LSB of each word first.
- `data_ready`  in  1  consumer accepts the head word.
- `clr_overflow`  in  1  synchronous clear of `overflow`.
- `data_out`  out  DATA_WIDTH  FIFO head word; reads 0 while empty.
- `data_valid`  out  1  FIFO not empty.
- `fifo_level`  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- `overflow`  out  1  sticky: a completed word was dropped.
- `parity_err`  out  1  one-cycle pulse; present only with `BLOCK_C_PARITY_EN` defined.

## Operation
- **Reset:** all outputs are 0 at reset. FIFO is empty, `bit_cnt` = 0, FSM is in `SHIFT`, and any partially assembled word is discarded. Reset asserted mid-word or mid-handshake behaves identically.
- **FSM states:** `SHIFT`, plus `PARITY` when `BLOCK_C_PARITY_EN` is defined.
- **SHIFT:** on each edge with `data_en`=1:
  - `shreg[bit_cnt]` <= `data_in_out_2`.
  - `bit_cnt` increments.
  - When `bit_cnt` == `DATA_WIDTH-1`, the word is complete and equals {`data_in_out_2`, `shreg[DATA_WIDTH-2:0]`}. `bit_cnt` wraps to 0.
  - Without parity, the complete word is pushed at that same edge. With parity, the FSM moves to `PARITY` instead.
- **data_en gaps:** cycles with `data_en`=0 hold all assembly state. Gaps of any length are legal, including mid-word.
- **Push:**
  - Accepted if the FIFO is not full, or if it is full and a pop occurs on the same edge.
  - Otherwise the word is dropped and `overflow` <= 1.
- **Pop:** occurs when `data_valid`=1 and `data_ready`=1; `rd_ptr` advances.
- **Simultaneous push and pop:** `fifo_level` is unchanged. When the FIFO was empty, a same-edge push with no pop raises the level to 1.
- **overflow flag:** cleared by `clr_overflow`=1. If a new drop occurs on the same edge as the clear, set wins.
- **Pointers:** wrap modulo `FIFO_DEPTH`. Full is `fifo_level`==`FIFO_DEPTH`; empty is `fifo_level`==0.

## Timing
- **Word latency:** the last data bit (or the parity bit) is sampled at edge N. `data_valid`=1 and `data_out` equals the word in the cycle after edge N, provided the FIFO was previously empty.
- **Throughput:** one word per `DATA_WIDTH` strobes, or `DATA_WIDTH+1` with parity. A pop every cycle is sustainable.
- **Output registration:** `data_out` is `mem[rd_ptr]` (show-ahead); `data_valid` and `fifo_level` are registered.
- **Handshake:** `data_out` and `data_valid` remain stable while `data_valid`=1 and `data_ready`=0.
- **parity_err:** high for exactly the cycle after the failing parity-bit edge.

## Configuration
- Macro: `BLOCK_C_PARITY_EN`.
- **Defined:**
  - After `DATA_WIDTH` data bits the FSM enters `PARITY`.
  - The next strobed bit p is checked for even parity over data plus p.
  - If the reduction-XOR of the word XOR p equals 0, the word is pushed.
  - Otherwise the word is discarded, not pushed, and `parity_err` pulses.
  - The FSM returns to `SHIFT` in both cases.
- **Undefined:** no `PARITY` state, no `parity_err` port, and the word is pushed on the last data bit.

## Structure
- **Package `block_c_pkg`:**
  - FSM state enum typedef (`SHIFT`, `PARITY`).
  - `DATA_WIDTH_MAX` = 32.
  - Function returning the level width for a given depth.
- **Sub-module `block_c_fifo`:** parameterized show-ahead FIFO with push/pop, level, and a drop indication. The top level holds the FSM, shift register, `bit_cnt`, and the `overflow`/`parity_err` logic.

## Test plan
All scenarios use `DATA_WIDTH`=8 and `FIFO_DEPTH`=4.
- **Basic capture:** strobe bits 1,0,1,0,0,1,0,1 on consecutive cycles with `data_ready`=1 -> `data_out`=0xA5 and `data_valid`=1 for one cycle after the 8th bit edge; `fifo_level` returns to 0.
- **Gapped strobes:** insert 3-cycle `data_en` gaps between bits of 0x3C -> same single word 0x3C; no extra words.
- **Overflow:** hold `data_ready`=0 and send 0x01..0x05 -> `fifo_level`=4, `overflow`=1 after the 5th word. Drain to get 0x01,0x02,0x03,0x04. Pulse `clr_overflow` -> `overflow`=0.
- **Full with same-edge pop:** with the FIFO full, complete word 0x77 on the same edge as a pop -> level stays 4, `overflow` stays 0, and 0x77 emerges last.
- **Reset mid-word:** assert `rst` after 5 bits, release, then send 0xC3 -> only 0xC3 is output.
- **Parity (`BLOCK_C_PARITY_EN` defined):** send 0xA5 with p=0 -> pushed. Send 0xA5 with p=1 -> not pushed, `parity_err` high for 1 cycle, `fifo_level` unchanged.
